// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the processor data port and instruction-fetch
// port. Both ports share one single-port 32-bit word RAM. The data port wins
// arbitration, a configurable number of wait states separate acceptance from
// response, and every access returns a one-cycle ready strobe.
//
// Handshake: iMemRead/iMemWrite/iInstRead are level requests that the
// requester holds, with stable address/data, until the matching ready strobe
// (oMemReady/oInstReady) is high for one cycle. The request is then dropped,
// or changed to the next access. Address and data are latched when the
// request is accepted, so changes after acceptance have no effect.
//
// Ports:
//   iClk, nRst              clock (rising edge), async active-low reset
//   iMemRead, iMemWrite     data-port read / write requests
//   iMemAddr, iMemData      data byte address / write data
//   oMemData, oMemReady     read data (held between reads) / completion strobe
//   iInstRead, iInstAddr    fetch request / fetch byte address
//   oInstData, oInstReady   fetched word (held) / completion strobe
//   oAddrErr                strobes with ready for an out-of-range address
//   oDbgState               current FSM state, for observation only
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iMemAddr,
  input  logic [31:0] iMemData,
  output logic [31:0] oMemData,
  output logic        oMemReady,
  input  logic        iInstRead,
  input  logic [31:0] iInstAddr,
  output logic [31:0] oInstData,
  output logic        oInstReady,
  output logic        oAddrErr,
  output logic [1:0]  oDbgState
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         WAIT_M1   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_M1);

  logic [31:0]       r_ram [DEPTH];

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_port_inst;
  logic              r_write;
  logic [ADDR_W-1:0] r_idx;
  logic              r_in_range;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem_data;
  logic [31:0]       r_inst_data;
  logic              r_mem_ready;
  logic              r_inst_ready;
  logic              r_addr_err;

  logic              w_data_req;
  logic              w_req_any;
  logic [31:0]       w_sel_addr;
  logic [ADDR_W-1:0] w_sel_idx;
  logic              w_sel_in_range;
  logic              w_sel_inst;
  logic              w_fire_now;
  logic              w_fire_wait;
  logic              w_fire;
  logic              w_cur_inst;
  logic              w_cur_write;
  logic [ADDR_W-1:0] w_cur_idx;
  logic              w_cur_in_range;
  logic [31:0]       w_cur_wdata;
  logic [31:0]       w_rd_word;
  logic              w_unused_addr_bits;

  // Byte-offset bits never select anything; words are always whole.
  assign w_unused_addr_bits = &{1'b0, iMemAddr[1:0], iInstAddr[1:0]};

  // Arbitration: any data request (read, write or both) beats a fetch.
  // A simultaneous read+write is a write because r_write follows iMemWrite.
  assign w_data_req     = iMemRead | iMemWrite;
  assign w_req_any      = w_data_req | iInstRead;
  assign w_sel_addr     = w_data_req ? iMemAddr : iInstAddr;
  assign w_sel_idx      = w_sel_addr[ADDR_W+1:2];
  assign w_sel_in_range = (w_sel_addr[31:ADDR_W+2] == '0);
  assign w_sel_inst     = ~w_data_req;

  // The access is performed on the edge that enters RESP. With no wait
  // states that edge is the acceptance edge itself, so the live request
  // fields are used instead of the (not yet loaded) latched ones.
  assign w_fire_now  = (r_state == S_IDLE) && w_req_any && (WAIT_CYCLES == 0);
  assign w_fire_wait = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_fire      = w_fire_now | w_fire_wait;

  assign w_cur_inst     = w_fire_now ? w_sel_inst     : r_port_inst;
  assign w_cur_write    = w_fire_now ? iMemWrite      : r_write;
  assign w_cur_idx      = w_fire_now ? w_sel_idx      : r_idx;
  assign w_cur_in_range = w_fire_now ? w_sel_in_range : r_in_range;
  assign w_cur_wdata    = w_fire_now ? iMemData       : r_wdata;

  assign w_rd_word = w_cur_in_range ? r_ram[w_cur_idx] : 32'd0;

  // RAM array carries no reset. Gating with nRst keeps a write from
  // committing while reset is held.
  always_ff @(posedge iClk) begin
    if (nRst && w_fire && w_cur_write && !w_cur_inst && w_cur_in_range) begin
      r_ram[w_cur_idx] <= w_cur_wdata;
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_port_inst  <= 1'b0;
      r_write      <= 1'b0;
      r_idx        <= '0;
      r_in_range   <= 1'b0;
      r_wdata      <= '0;
      r_mem_data   <= '0;
      r_inst_data  <= '0;
      r_mem_ready  <= 1'b0;
      r_inst_ready <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_mem_ready  <= 1'b0;
      r_inst_ready <= 1'b0;
      r_addr_err   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_port_inst <= w_sel_inst;
            r_write     <= iMemWrite;
            r_idx       <= w_sel_idx;
            r_in_range  <= w_sel_in_range;
            r_wdata     <= iMemData;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        // One idle cycle after the response lets the requester drop its
        // level request before IDLE samples again.
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_fire) begin
        r_addr_err <= ~w_cur_in_range;
        if (w_cur_inst) begin
          r_inst_data  <= w_rd_word;
          r_inst_ready <= 1'b1;
        end else begin
          r_mem_ready <= 1'b1;
          if (!w_cur_write) begin
            r_mem_data <= w_rd_word;
          end
        end
      end
    end
  end

  assign oMemData   = r_mem_data;
  assign oMemReady  = r_mem_ready;
  assign oInstData  = r_inst_data;
  assign oInstReady = r_inst_ready;
  assign oAddrErr   = r_addr_err;
  assign oDbgState  = r_state;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's data port (mem_read/mem_write/mem_addr/mem_data) and instruction-fetch port.
- Backs both ports with a single-port word RAM. Arbitrates between the ports, inserts a configurable number of wait states, and returns a one-cycle ready strobe per access.
- Sits between the processor top level and the system memory. The processor control unit stalls on the ready strobes.

Parameters:
ADDR_W, 9, word-address width; RAM depth = 2**ADDR_W words of 32 bits
WAIT_CYCLES, 1, wait states inserted between request acceptance and response (0..15)

Ports:
iClk  in  1  system clock, rising-edge
nRst  in  1  asynchronous active-low reset
iMemRead  in  1  data read request, level, held until oMemReady
iMemWrite  in  1  data write request, level, held until oMemReady
iMemAddr  in  32  data byte address
iMemData  in  32  write data (processor mem_data_out)
oMemData  out  32  read data (processor mem_data_in)
oMemReady  out  1  one-cycle strobe: data access complete
iInstRead  in  1  fetch request, level, held until oInstReady
iInstAddr  in  32  fetch byte address
oInstData  out  32  fetched instruction
oInstReady  out  1  one-cycle strobe: fetch complete
oAddrErr  out  1  one-cycle strobe with ready: address out of range

Behaviour:
- Reset (nRst low, asynchronous):
  - state = IDLE; wait counter = 0.
  - oMemData, oInstData, oMemReady, oInstReady and oAddrErr all = 0.
  - RAM contents are not cleared.
- Addressing:
  - Word index = addr[ADDR_W+1:2]; addr[1:0] are ignored.
  - The address is in range iff addr[31:ADDR_W+2] == 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Samples the requests each rising edge.
  - Data port has priority over the instruction port.
  - On acceptance, latches port ID, op, word index, range flag and write data.
  - Moves to WAIT if WAIT_CYCLES > 0, otherwise directly to RESP.
  - With no request, stays in IDLE.
- WAIT:
  - Counter counts from WAIT_CYCLES-1 down to 0, then moves to RESP.
  - New requests are ignored.
- Entering RESP (registered outputs for exactly one cycle):
  - Data read: oMemData <= RAM[idx] (0 if out of range); oMemReady = 1.
  - Data write: RAM[idx] <= latched data, only if in range; oMemReady = 1; oMemData unchanged.
  - Fetch: oInstData <= RAM[idx] (0 if out of range); oInstReady = 1.
  - oAddrErr = 1 for an out-of-range access.
- RESP always returns to IDLE. This idle cycle lets the requester drop its level request before it is re-sampled, so each held request is served once.
- Latency: request first sampled at edge E. Ready is high during cycle E + 1 + WAIT_CYCLES. Back-to-back accesses from one port are spaced WAIT_CYCLES + 2 cycles apart.
- Simultaneous iMemRead and iMemWrite: treated as a write; the read is dropped.
- Simultaneous data and fetch requests: data is served first; the fetch stays pending and is accepted on the next IDLE.
- oMemData and oInstData hold their last value between responses.
- Requests changing address or data while in WAIT/RESP: no effect, because the latched values are used.
- Reset mid-operation: the access is aborted.
  - A write whose RESP edge has not occurred is not committed.
  - No ready strobe is issued; after reset, state is IDLE.
- Reading and writing the same word in consecutive accesses: the read returns the newly written value.

Test Plan:
- Reset with WAIT_CYCLES=1:
  - Stimulus: nRst low for 15 ns, released between edges.
  - Response: all outputs 0; no strobes for 5 idle cycles.
- Data write then read:
  - Stimulus: write 0xDEADBEEF to 0x00000010 with WAIT_CYCLES=1; later read 0x00000010.
  - Response: oMemReady pulses 2 cycles after the first sampling edge; oMemData = 0xDEADBEEF; addr 0x00000013 reads the same word.
- Contention:
  - Stimulus: iInstRead at 0x0 and iMemRead at 0x10 asserted on the same edge.
  - Response: oMemReady first; oInstReady 3 cycles later; RAM[0] previously loaded with 0x12345678 appears on oInstData.
- Out-of-range write (ADDR_W=9):
  - Stimulus: write 0x55 to 0x00000800.
  - Response: oMemReady and oAddrErr pulse together; a subsequent read of 0x0 shows RAM[0] unchanged.
- Reset mid-write (WAIT_CYCLES=3):
  - Stimulus: write 0xA5A5A5A5 to 0x20; assert nRst during WAIT.
  - Response: no oMemReady; a later read of 0x20 returns the prior contents.
- WAIT_CYCLES=0 back-to-back fetches:
  - Stimulus: fetches at 0x0, 0x4, 0x8, each dropped after its ready.
  - Response: one oInstReady per fetch, spaced 2 cycles apart; each fetch served exactly once.
